universal_shift_reg_param: RTL and testbench
============================================

UNIVERSAL_SHIFT_REG_PARAM -- requirements
Module: universal_shift_reg_param

Interface
- REQ-001 SHALL have parameter: WIDTH, 8, register width in bits (legal range 2..64).
- REQ-002 SHALL have parameter: CNT_W, 8, width of the shift-operation counter.
- REQ-003 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
- REQ-004 SHALL have port: reset_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
- REQ-005 SHALL have port: en  input  1  operation enable; 0 forces hold of all state.
- REQ-006 SHALL have port: sel  input  3  mode select, encoding per REQ-011.
- REQ-007 SHALL have port: ser_in_r  input  1  serial bit entering MSB on shift-right.
- REQ-008 SHALL have port: ser_in_l  input  1  serial bit entering LSB on shift-left.
- REQ-009 SHALL have ports: data_in  input  WIDTH  parallel load word; data_out  output  WIDTH  register contents; ser_out_r  output  1  equals data_out[0]; ser_out_l  output  1  equals data_out[WIDTH-1]; shift_cnt  output  CNT_W  shifts since last load/clear; zero  output  1  registered flag, high when data_out is all zeros.

Function
- REQ-010 SHALL update data_out, shift_cnt and zero only on a rising clk edge where reset_n=1 and en=1; otherwise all three hold their values.
- REQ-011 SHALL decode sel: 000 hold; 001 shift right {ser_in_r, data_out[WIDTH-1:1]}; 010 shift left {data_out[WIDTH-2:0], ser_in_l}; 011 parallel load data_in; 100 rotate right {data_out[0], data_out[WIDTH-1:1]}; 101 rotate left {data_out[WIDTH-2:0], data_out[WIDTH-1]}; 110 arithmetic shift right {data_out[WIDTH-1], data_out[WIDTH-1:1]}; 111 clear to all zeros.
- REQ-012 SHALL have a latency of one clock: the result of the mode sampled at edge N is visible on data_out immediately after edge N.
- REQ-013 SHALL drive ser_out_r and ser_out_l combinationally from the current data_out (no extra register stage).
- REQ-014 SHALL increment shift_cnt by 1 on every enabled edge executing modes 001, 010, 100, 101 or 110.
- REQ-015 SHALL saturate shift_cnt at all-ones (2^CNT_W-1); further shifts leave it unchanged, with no wrap to zero.
- REQ-016 SHALL reset shift_cnt to 0 on modes 011 (load) and 111 (clear); hold (000) leaves it unchanged.
- REQ-017 SHALL compute zero from the next-state value of data_out, so that zero and data_out change on the same edge.
- REQ-018 SHALL ignore ser_in_r and ser_in_l in every mode except 001 and 010 respectively.
- REQ-019 SHALL treat any X/illegal sel value as hold (the default branch).

Reset
- REQ-020 SHALL, on an edge with reset_n=0, set data_out=0, shift_cnt=0 and zero=1, regardless of en and sel.
- REQ-021 SHALL give reset priority over en and all modes, including a reset asserted mid-sequence; the first enabled edge after reset_n rises operates on the all-zero state.
- REQ-022 SHALL NOT respond to reset_n asynchronously; outputs keep their values between edges while reset_n=0.

Configuration
- REQ-023 SHALL compile the rotate modes (100, 101) only when macro USR_ROTATE_EN is defined.
- REQ-024 SHALL, without USR_ROTATE_EN, decode sel 100 and 101 as hold: data_out, shift_cnt and zero remain unchanged.
- REQ-025 SHALL keep every other mode, and all reset behaviour, identical with and without USR_ROTATE_EN.

Verification (WIDTH=8, CNT_W=8 unless stated)
- REQ-026 SHALL cover: reset_n=0 for 2 edges, then load 0xA5 -> data_out=0xA5, shift_cnt=0, zero=0, ser_out_l=1, ser_out_r=1.
- REQ-027 SHALL cover: from 0xA5, shift-right with ser_in_r=1, then shift-left with ser_in_l=0 -> data_out=0xD2 then 0xA4, shift_cnt=2.
- REQ-028 SHALL cover: load 0x81, then rotate-left twice -> 0x03 then 0x06 with USR_ROTATE_EN defined; 0x81 held and shift_cnt=0 without it.
- REQ-029 SHALL cover: load 0x80, arithmetic shift right 3 times -> 0xC0, 0xE0, 0xF0; then clear -> 0x00, zero=1, shift_cnt=0.
- REQ-030 SHALL cover: CNT_W=2, 5 consecutive shift-rights -> shift_cnt sequence 1,2,3,3,3; an en=0 edge between shifts leaves data_out and shift_cnt unchanged.
- REQ-031 SHALL cover: reset_n=0 asserted together with sel=011 and en=1 -> data_out=0, zero=1, shift_cnt=0 (reset wins).

Source files
------------

// File: rtl/universal_shift_reg_param.sv
// universal_shift_reg_param
//   Parameterised universal shift register with a saturating shift-operation
//   counter and a registered all-zero flag.
//
//   Parameters
//     WIDTH  register width in bits (2..64)
//     CNT_W  width of the shift-operation counter
//
//   Ports
//     clk        clock, all state updates on the rising edge
//     reset_n    synchronous active-low reset
//     en         operation enable; low holds all state
//     sel        mode select:
//                  000 hold        001 shift right   010 shift left
//                  011 load        100 rotate right  101 rotate left
//                  110 arith. shift right            111 clear
//     ser_in_r   serial bit entering the MSB on shift right
//     ser_in_l   serial bit entering the LSB on shift left
//     data_in    parallel load word
//     data_out   register contents
//     ser_out_r  data_out[0]
//     ser_out_l  data_out[WIDTH-1]
//     shift_cnt  shifts since the last load/clear, saturating at all-ones
//     zero       registered flag, high when data_out is all zeros
//
//   Configuration
//     USR_ROTATE_EN  when defined, enables rotate modes 100/101; otherwise
//                    those encodings behave as hold.
module universal_shift_reg_param #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic [2:0]       sel,
  input  logic             ser_in_r,
  input  logic             ser_in_l,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             ser_out_r,
  output logic             ser_out_l,
  output logic [CNT_W-1:0] shift_cnt,
  output logic             zero
);

  localparam logic [2:0] SEL_SHR   = 3'b001;
  localparam logic [2:0] SEL_SHL   = 3'b010;
  localparam logic [2:0] SEL_LOAD  = 3'b011;
  localparam logic [2:0] SEL_ROR   = 3'b100;
  localparam logic [2:0] SEL_ROL   = 3'b101;
  localparam logic [2:0] SEL_ASR   = 3'b110;
  localparam logic [2:0] SEL_CLEAR = 3'b111;

  logic [WIDTH-1:0] data_next;
  logic [CNT_W-1:0] cnt_next;
  logic             shift_op;
  logic             cnt_clr;

  // Hold (000), unknown sel and, without rotate support, 100/101 all fall
  // through to the default: data unchanged, counter unchanged.
  always_comb begin
    data_next = data_out;
    shift_op  = 1'b0;
    cnt_clr   = 1'b0;
    case (sel)
      SEL_SHR: begin
        data_next = {ser_in_r, data_out[WIDTH-1:1]};
        shift_op  = 1'b1;
      end
      SEL_SHL: begin
        data_next = {data_out[WIDTH-2:0], ser_in_l};
        shift_op  = 1'b1;
      end
      SEL_LOAD: begin
        data_next = data_in;
        cnt_clr   = 1'b1;
      end
`ifdef USR_ROTATE_EN
      SEL_ROR: begin
        data_next = {data_out[0], data_out[WIDTH-1:1]};
        shift_op  = 1'b1;
      end
      SEL_ROL: begin
        data_next = {data_out[WIDTH-2:0], data_out[WIDTH-1]};
        shift_op  = 1'b1;
      end
`endif
      SEL_ASR: begin
        data_next = {data_out[WIDTH-1], data_out[WIDTH-1:1]};
        shift_op  = 1'b1;
      end
      SEL_CLEAR: begin
        data_next = '0;
        cnt_clr   = 1'b1;
      end
      default: ;
    endcase
  end

  // Counter saturates at all-ones rather than wrapping.
  always_comb begin
    cnt_next = shift_cnt;
    if (cnt_clr)
      cnt_next = '0;
    else if (shift_op && (shift_cnt != '1))
      cnt_next = shift_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data_out  <= '0;
      shift_cnt <= '0;
      zero      <= 1'b1;
    end else if (en) begin
      data_out  <= data_next;
      shift_cnt <= cnt_next;
      // Flag derived from the next-state word so it tracks data_out exactly.
      zero      <= (data_next == '0);
    end
  end

  assign ser_out_r = data_out[0];
  assign ser_out_l = data_out[WIDTH-1];

endmodule

// File: tb/tb_universal_shift_reg_param.sv
// tb_universal_shift_reg_param
//   Self-checking bench for universal_shift_reg_param. Two instances share
//   all inputs: dut_a (WIDTH=8, CNT_W=8) and dut_b (WIDTH=8, CNT_W=2, for
//   counter saturation). A behavioural model tracks the expected state.
module tb_universal_shift_reg_param;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       en = 1'b0;
  logic [2:0] sel = 3'b000;
  logic       ser_in_r = 1'b0;
  logic       ser_in_l = 1'b0;
  logic [7:0] data_in = 8'h00;

  logic [7:0] data_out_a, data_out_b;
  logic       ser_out_r_a, ser_out_l_a, ser_out_r_b, ser_out_l_b;
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;
  logic       zero_a, zero_b;

  int checks = 0;
  int failures = 0;

  // behavioural model state
  logic [7:0] m_d;
  logic       m_z;
  int         m_ca;
  int         m_cb;

  always #5 clk = ~clk;

  universal_shift_reg_param #(.WIDTH(8), .CNT_W(8)) dut_a (
    .clk(clk), .reset_n(reset_n), .en(en), .sel(sel),
    .ser_in_r(ser_in_r), .ser_in_l(ser_in_l), .data_in(data_in),
    .data_out(data_out_a), .ser_out_r(ser_out_r_a), .ser_out_l(ser_out_l_a),
    .shift_cnt(cnt_a), .zero(zero_a)
  );

  universal_shift_reg_param #(.WIDTH(8), .CNT_W(2)) dut_b (
    .clk(clk), .reset_n(reset_n), .en(en), .sel(sel),
    .ser_in_r(ser_in_r), .ser_in_l(ser_in_l), .data_in(data_in),
    .data_out(data_out_b), .ser_out_r(ser_out_r_b), .ser_out_l(ser_out_l_b),
    .shift_cnt(cnt_b), .zero(zero_b)
  );

  // Reference behaviour in plain arithmetic on the 8-bit value.
  task automatic model_step(input logic rn, input logic en_i, input logic [2:0] s,
                            input logic sr, input logic sl, input logic [7:0] din);
    int v;
    int r;
    bit shift;
    v = int'(m_d);
    r = v;
    shift = 1'b0;
    if (!rn) begin
      m_d = 8'h00; m_ca = 0; m_cb = 0; m_z = 1'b1;
    end else if (en_i) begin
      case (s)
        3'd1: begin r = v / 2 + (sr ? 128 : 0); shift = 1'b1; end
        3'd2: begin r = (v * 2) % 256 + (sl ? 1 : 0); shift = 1'b1; end
        3'd3: begin r = int'(din); m_ca = 0; m_cb = 0; end
`ifdef USR_ROTATE_EN
        3'd4: begin r = v / 2 + (v % 2) * 128; shift = 1'b1; end
        3'd5: begin r = (v * 2) % 256 + v / 128; shift = 1'b1; end
`endif
        3'd6: begin r = v / 2 + (v >= 128 ? 128 : 0); shift = 1'b1; end
        3'd7: begin r = 0; m_ca = 0; m_cb = 0; end
        default: r = v;
      endcase
      m_d = 8'(r);
      if (shift) begin
        if (m_ca < 255) m_ca++;
        if (m_cb < 3) m_cb++;
      end
      m_z = (r == 0);
    end
  endtask

  // Drive one clock of stimulus and advance the model; sampling happens #1 after the edge.
  task automatic tick(input logic rn, input logic en_i, input logic [2:0] s,
                      input logic sr, input logic sl, input logic [7:0] din);
    reset_n = rn; en = en_i; sel = s; ser_in_r = sr; ser_in_l = sl; data_in = din;
    @(posedge clk);
    model_step(rn, en_i, s, sr, sl, din);
    #1;
  endtask

  task automatic test_reset;
    tick(1'b0, 1'b1, 3'b011, 1'b1, 1'b1, 8'hFF);
    tick(1'b0, 1'b1, 3'b011, 1'b1, 1'b1, 8'hFF);
    checks++;
    if ({data_out_a, cnt_a, zero_a} !== {8'h00, 8'h00, 1'b1}) begin
      failures++;
      $display("FAIL reset_a got=%h/%h/%b want=00/00/1", data_out_a, cnt_a, zero_a);
    end
    checks++;
    if ({data_out_b, cnt_b, zero_b} !== {8'h00, 2'd0, 1'b1}) begin
      failures++;
      $display("FAIL reset_b got=%h/%h/%b want=00/0/1", data_out_b, cnt_b, zero_b);
    end
  endtask

  task automatic test_load_shift;
    tick(1'b1, 1'b1, 3'b011, 1'b0, 1'b0, 8'hA5);
    checks++;
    if ({data_out_a, cnt_a, zero_a, ser_out_l_a, ser_out_r_a} !== {8'hA5, 8'h00, 1'b0, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL load_a5 got=%h/%h/%b/%b/%b want=a5/00/0/1/1",
               data_out_a, cnt_a, zero_a, ser_out_l_a, ser_out_r_a);
    end
    tick(1'b1, 1'b1, 3'b001, 1'b1, 1'b1, 8'h00);
    checks++;
    if ({data_out_a, cnt_a} !== {8'hD2, 8'h01}) begin
      failures++;
      $display("FAIL shr got=%h/%h want=d2/01", data_out_a, cnt_a);
    end
    tick(1'b1, 1'b1, 3'b010, 1'b1, 1'b0, 8'h00);
    checks++;
    if ({data_out_a, cnt_a, zero_a} !== {8'hA4, 8'h02, 1'b0}) begin
      failures++;
      $display("FAIL shl got=%h/%h/%b want=a4/02/0", data_out_a, cnt_a, zero_a);
    end
  endtask

  task automatic test_rotate;
    logic [7:0] exp_d [2];
    logic [7:0] exp_c [2];
`ifdef USR_ROTATE_EN
    exp_d[0] = 8'h03; exp_d[1] = 8'h06; exp_c[0] = 8'h01; exp_c[1] = 8'h02;
`else
    exp_d[0] = 8'h81; exp_d[1] = 8'h81; exp_c[0] = 8'h00; exp_c[1] = 8'h00;
`endif
    tick(1'b1, 1'b1, 3'b011, 1'b0, 1'b0, 8'h81);
    for (int i = 0; i < 2; i++) begin
      tick(1'b1, 1'b1, 3'b101, 1'b1, 1'b1, 8'h00);
      checks++;
      if ({data_out_a, cnt_a, zero_a} !== {exp_d[i], exp_c[i], 1'b0}) begin
        failures++;
        $display("FAIL rotl_%0d got=%h/%h/%b want=%h/%h/0", i, data_out_a, cnt_a, zero_a,
                 exp_d[i], exp_c[i]);
      end
    end
  endtask

  task automatic test_asr_clear;
    logic [7:0] exp_d [3];
    exp_d[0] = 8'hC0; exp_d[1] = 8'hE0; exp_d[2] = 8'hF0;
    tick(1'b1, 1'b1, 3'b011, 1'b0, 1'b0, 8'h80);
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b1, 3'b110, 1'b0, 1'b0, 8'h00);
      checks++;
      if ({data_out_a, cnt_a} !== {exp_d[i], 8'(i + 1)}) begin
        failures++;
        $display("FAIL asr_%0d got=%h/%h want=%h/%h", i, data_out_a, cnt_a, exp_d[i], 8'(i + 1));
      end
    end
    tick(1'b1, 1'b1, 3'b111, 1'b1, 1'b1, 8'hFF);
    checks++;
    if ({data_out_a, cnt_a, zero_a} !== {8'h00, 8'h00, 1'b1}) begin
      failures++;
      $display("FAIL clear got=%h/%h/%b want=00/00/1", data_out_a, cnt_a, zero_a);
    end
  endtask

  task automatic test_saturation;
    logic [1:0] exp_c [5];
    logic [7:0] held_d;
    logic [1:0] held_c;
    exp_c[0] = 2'd1; exp_c[1] = 2'd2; exp_c[2] = 2'd3; exp_c[3] = 2'd3; exp_c[4] = 2'd3;
    tick(1'b1, 1'b1, 3'b111, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, 1'b1, 3'b001, 1'b1, 1'b0, 8'h00);
      checks++;
      if ({data_out_b, cnt_b} !== {m_d, exp_c[i]}) begin
        failures++;
        $display("FAIL sat_%0d got=%h/%0d want=%h/%0d", i, data_out_b, cnt_b, m_d, exp_c[i]);
      end
      if (i == 1) begin
        held_d = data_out_b;
        held_c = cnt_b;
        tick(1'b1, 1'b0, 3'b001, 1'b0, 1'b0, 8'h55);
        checks++;
        if ({data_out_b, cnt_b} !== {8'hC0, 2'd2}) begin
          failures++;
          $display("FAIL en_low_hold got=%h/%0d want=c0/2 (was %h/%0d)", data_out_b, cnt_b,
                   held_d, held_c);
        end
      end
    end
  endtask

  task automatic test_x_sel;
    tick(1'b1, 1'b1, 3'b011, 1'b0, 1'b0, 8'h3C);
    tick(1'b1, 1'b1, 3'bxxx, 1'b1, 1'b1, 8'hFF);
    checks++;
    if ({data_out_a, cnt_a, zero_a} !== {8'h3C, 8'h00, 1'b0}) begin
      failures++;
      $display("FAIL x_sel_hold got=%h/%h/%b want=3c/00/0", data_out_a, cnt_a, zero_a);
    end
  endtask

  task automatic test_reset_midseq;
    tick(1'b1, 1'b1, 3'b011, 1'b0, 1'b0, 8'h5A);
    tick(1'b1, 1'b1, 3'b001, 1'b0, 1'b0, 8'h00);
    #1 reset_n = 1'b0;
    #2;
    checks++;
    if ({data_out_a, cnt_a, zero_a} !== {8'h2D, 8'h01, 1'b0}) begin
      failures++;
      $display("FAIL no_async_reset got=%h/%h/%b want=2d/01/0", data_out_a, cnt_a, zero_a);
    end
    tick(1'b0, 1'b1, 3'b011, 1'b0, 1'b0, 8'hEE);
    checks++;
    if ({data_out_a, cnt_a, zero_a} !== {8'h00, 8'h00, 1'b1}) begin
      failures++;
      $display("FAIL reset_wins got=%h/%h/%b want=00/00/1", data_out_a, cnt_a, zero_a);
    end
    tick(1'b1, 1'b1, 3'b001, 1'b1, 1'b0, 8'h00);
    checks++;
    if ({data_out_a, cnt_a, zero_a} !== {8'h80, 8'h01, 1'b0}) begin
      failures++;
      $display("FAIL post_reset_shr got=%h/%h/%b want=80/01/0", data_out_a, cnt_a, zero_a);
    end
  endtask

  task automatic test_random;
    logic [20:0] exp_a, act_a;
    logic [14:0] exp_b, act_b;
    for (int i = 0; i < 400; i++) begin
      tick(($urandom_range(0, 29) != 0), ($urandom_range(0, 3) != 0), 3'($urandom),
           1'($urandom), 1'($urandom), 8'($urandom));
      exp_a = {m_d, 8'(m_ca), m_z, m_d[7], m_d[0]};
      act_a = {data_out_a, cnt_a, zero_a, ser_out_l_a, ser_out_r_a};
      exp_b = {m_d, 2'(m_cb), m_z, m_d[7], m_d[0]};
      act_b = {data_out_b, cnt_b, zero_b, ser_out_l_b, ser_out_r_b};
      checks++;
      if (act_a !== exp_a) begin
        failures++;
        $display("FAIL rand_a_%0d got=%h want=%h", i, act_a, exp_a);
      end
      checks++;
      if (act_b !== exp_b) begin
        failures++;
        $display("FAIL rand_b_%0d got=%h want=%h", i, act_b, exp_b);
      end
    end
  endtask

  initial begin
    m_d = 8'h00; m_z = 1'b1; m_ca = 0; m_cb = 0;
    @(negedge clk);
    test_reset();
    test_load_shift();
    test_rotate();
    test_asr_clear();
    test_saturation();
    test_x_sel();
    test_reset_midseq();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
